// File: rtl/pin_trigger_pkg.sv
// Shared encodings for the pin trigger unit: FSM states, channel edge modes
// and the channel combine selector.
package pin_trigger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } trig_state_e;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_ANY  = 2'b11;

    localparam logic COMBINE_OR  = 1'b0;
    localparam logic COMBINE_AND = 1'b1;

endpackage

// File: rtl/pin_edge_matcher.sv
// Per-channel edge detector: keeps the previous sample and a valid flag, and
// reduces the enabled channel matches by OR or AND.
module pin_edge_matcher
    import pin_trigger_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sample_en,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [2*WIDTH-1:0] i_mode,
    input  logic               i_combine,
    output logic               o_match,
    output logic               o_changed
);

    logic [WIDTH-1:0] r_prev;
    logic             r_valid;
    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_en;
    logic [1:0]       w_mode_k;

    // Edge reference follows every sample, independent of the capture FSM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev  <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else if (i_sample_en) begin
            r_prev  <= i_data;
            r_valid <= 1'b1;
        end else begin
            r_prev  <= r_prev;
            r_valid <= r_valid;
        end
    end

    // Per-channel edge qualification against the stored reference.
    always_comb begin
        w_hit    = {WIDTH{1'b0}};
        w_en     = {WIDTH{1'b0}};
        w_mode_k = MODE_OFF;
        for (int k = 0; k < WIDTH; k++) begin
            w_mode_k = i_mode[2*k +: 2];
            w_en[k]  = (w_mode_k != MODE_OFF);
            case (w_mode_k)
                MODE_RISE: w_hit[k] = ~r_prev[k] & i_data[k];
                MODE_FALL: w_hit[k] = r_prev[k] & ~i_data[k];
                MODE_ANY:  w_hit[k] = r_prev[k] ^ i_data[k];
                default:   w_hit[k] = 1'b0;
            endcase
        end
    end

    // An empty enable set must not satisfy the AND reduction.
    always_comb begin
        if (!r_valid) begin
            o_match = 1'b0;
        end else if (i_combine == COMBINE_AND) begin
            o_match = (|w_en) && ((w_hit & w_en) == w_en);
        end else begin
            o_match = |(w_hit & w_en);
        end
    end

    assign o_changed = r_valid && (r_prev != i_data);

endmodule

// File: rtl/pin_trigger_unit.sv
// Sequenced trigger/capture controller: pre-trigger window, armed match search
// and post-trigger window. Optional match occurrence count: PIN_TRIGGER_OCCURRENCE_EN.
module pin_trigger_unit
    import pin_trigger_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sample_en,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [2*WIDTH-1:0] i_mode,
    input  logic               i_combine,
    input  logic [CNT_W-1:0]   i_pre,
    input  logic [CNT_W-1:0]   i_post,
`ifdef PIN_TRIGGER_OCCURRENCE_EN
    input  logic [CNT_W-1:0]   i_occur,
`endif
    input  logic               i_arm,
    input  logic               i_abort,
    output logic [2:0]         o_state,
    output logic               o_changed,
    output logic               o_trig,
    output logic               o_capture,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_done
);

    trig_state_e      r_state;
    trig_state_e      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_match;
    logic             w_changed;
    logic             w_capture;
    logic             w_trig;
    logic             w_occ_hit;
`ifdef PIN_TRIGGER_OCCURRENCE_EN
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] w_occ_next;
`endif

    logic             r_trig;
    logic             r_capture;
    logic [WIDTH-1:0] r_data;
    logic             r_changed;
    logic             r_done;

    pin_edge_matcher #(
        .WIDTH(WIDTH)
    ) u_edge (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_sample_en (i_sample_en),
        .i_data      (i_data),
        .i_mode      (i_mode),
        .i_combine   (i_combine),
        .o_match     (w_match),
        .o_changed   (w_changed)
    );

    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, window counting and per-sample capture/trigger decisions.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_trig       = 1'b0;
`ifdef PIN_TRIGGER_OCCURRENCE_EN
        w_occ_next   = (r_state == ST_ARMED) ? r_occ : {CNT_W{1'b0}};
        w_occ_hit    = (r_occ == i_occur);
`else
        w_occ_hit    = 1'b1;
`endif
        if (i_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_arm) begin
                        w_cnt_next   = {CNT_W{1'b0}};
                        w_next_state = (i_pre == {CNT_W{1'b0}}) ? ST_ARMED : ST_PRE;
                    end else begin
                        w_next_state = r_state;
                    end
                end
                ST_PRE: begin
                    if (i_sample_en) begin
                        w_capture  = 1'b1;
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == i_pre) begin
                            w_next_state = ST_ARMED;
                        end else begin
                            w_next_state = ST_PRE;
                        end
                    end else begin
                        w_next_state = ST_PRE;
                    end
                end
                ST_ARMED: begin
                    if (i_sample_en) begin
                        w_capture = 1'b1;
                        if (w_match && w_occ_hit) begin
                            w_trig       = 1'b1;
                            w_cnt_next   = {CNT_W{1'b0}};
                            w_next_state = (i_post == {CNT_W{1'b0}}) ? ST_DONE : ST_POST;
                        end else if (w_match) begin
`ifdef PIN_TRIGGER_OCCURRENCE_EN
                            w_occ_next = r_occ + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
                        end else begin
                            w_next_state = ST_ARMED;
                        end
                    end else begin
                        w_next_state = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (i_sample_en) begin
                        w_capture  = 1'b1;
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == i_post) begin
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_state = ST_POST;
                        end
                    end else begin
                        w_next_state = ST_POST;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State and window counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
`ifdef PIN_TRIGGER_OCCURRENCE_EN
            r_occ   <= {CNT_W{1'b0}};
`endif
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
`ifdef PIN_TRIGGER_OCCURRENCE_EN
            r_occ   <= w_occ_next;
`endif
        end
    end

    // Output registers; o_data holds the last captured sample between captures.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_trig    <= 1'b0;
            r_capture <= 1'b0;
            r_data    <= {WIDTH{1'b0}};
            r_changed <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_trig    <= w_trig;
            r_capture <= w_capture;
            r_data    <= w_capture ? i_data : r_data;
            r_changed <= i_sample_en && w_changed;
            r_done    <= (w_next_state == ST_DONE);
        end
    end

    assign o_state   = r_state;
    assign o_trig    = r_trig;
    assign o_capture = r_capture;
    assign o_data    = r_data;
    assign o_changed = r_changed;
    assign o_done    = r_done;

endmodule

// File: tb/tb_pin_trigger_unit.sv
// Self-checking bench for pin_trigger_unit: directed scenarios plus a
// randomized run against a behavioural reference model.
`timescale 1ns/1ps
module tb_pin_trigger_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [7:0]  data;
    logic [15:0] mode;
    logic        combine;
    logic [15:0] pre;
    logic [15:0] post;
    logic [15:0] occur;
    logic        arm;
    logic        abort;

    wire [2:0]  o_state;
    wire        o_changed;
    wire        o_trig;
    wire        o_capture;
    wire [7:0]  o_data;
    wire        o_done;
    wire [14:0] act = {o_state, o_trig, o_capture, o_data, o_changed, o_done};

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         m_state;
    int         m_cnt;
    int         m_occ;
    bit [7:0]   m_prev;
    bit         m_valid;
    bit         e_trig;
    bit         e_cap;
    bit         e_chg;
    bit         e_done;
    bit [7:0]   e_data;
    logic [14:0] exp_vec = 15'd0;

    always #5 clk = ~clk;

    pin_trigger_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sample_en (sample_en),
        .i_data      (data),
        .i_mode      (mode),
        .i_combine   (combine),
        .i_pre       (pre),
        .i_post      (post),
`ifdef PIN_TRIGGER_OCCURRENCE_EN
        .i_occur     (occur),
`endif
        .i_arm       (arm),
        .i_abort     (abort),
        .o_state     (o_state),
        .o_changed   (o_changed),
        .o_trig      (o_trig),
        .o_capture   (o_capture),
        .o_data      (o_data),
        .o_done      (o_done)
    );

    function automatic bit model_match(input logic [7:0] p, input logic [7:0] c,
                                       input logic [15:0] md, input logic cb);
        int n_en;
        int n_hit;
        int m;
        n_en  = 0;
        n_hit = 0;
        for (int k = 0; k < 8; k++) begin
            m = int'((md >> (2 * k)) & 16'd3);
            if (m != 0) begin
                n_en++;
                if ((m == 1 && !p[k] && c[k]) || (m == 2 && p[k] && !c[k]) ||
                    (m == 3 && p[k] != c[k]))
                    n_hit++;
            end
        end
        if (n_en == 0) return 1'b0;
        return cb ? (n_hit == n_en) : (n_hit > 0);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit mt;
        int eff;
        e_trig = 1'b0;
        e_cap  = 1'b0;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_occ = 0; m_prev = 8'h00; m_valid = 1'b0;
            e_chg = 1'b0; e_data = 8'h00; e_done = 1'b0;
        end else begin
            e_chg = sample_en && m_valid && (m_prev != data);
            mt    = sample_en && m_valid && model_match(m_prev, data, mode, combine);
            eff   = 0;
`ifdef PIN_TRIGGER_OCCURRENCE_EN
            eff   = int'(occur);
`endif
            if (abort) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0, 4: if (arm) begin
                        m_cnt = 0; m_occ = 0;
                        m_state = (pre == 16'd0) ? 2 : 1;
                    end
                    1: if (sample_en) begin
                        e_cap = 1'b1; m_cnt++;
                        if (m_cnt == int'(pre)) begin m_state = 2; m_occ = 0; end
                    end
                    2: if (sample_en) begin
                        e_cap = 1'b1;
                        if (mt) begin
                            if (m_occ == eff) begin
                                e_trig = 1'b1; m_cnt = 0;
                                m_state = (post == 16'd0) ? 4 : 3;
                            end else begin
                                m_occ++;
                            end
                        end
                    end
                    3: if (sample_en) begin
                        e_cap = 1'b1; m_cnt++;
                        if (m_cnt == int'(post)) m_state = 4;
                    end
                    default: m_state = 0;
                endcase
            end
            if (e_cap) e_data = data;
            e_done = (m_state == 4);
            if (sample_en) begin m_prev = data; m_valid = 1'b1; end
        end
        exp_vec = {m_state[2:0], e_trig, e_cap, e_data, e_chg, e_done};
    endtask

    task automatic tick(input logic se, input logic [7:0] d, input logic a, input logic ab);
        @(negedge clk);
        sample_en = se; data = d; arm = a; abort = ab;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mode = 16'h0001; combine = 1'b0; pre = 16'd1; post = 16'd1;
        rst_n = 1'b0;
        tick(1'b1, 8'hFF, 1'b1, 1'b0);
        n_tests++;
        if (act !== 15'd0) begin n_fail++; $display("FAIL reset_outputs act=%h exp=0", act); end
        rst_n = 1'b1;
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        n_tests++;
        if (o_changed !== 1'b0) begin n_fail++; $display("FAIL first_sample_changed act=%b exp=0", o_changed); end
    endtask

    task automatic test_basic();
        int caps;
        int trigs;
        logic [7:0] d;
        caps = 0; trigs = 0;
        mode = 16'h0001; combine = 1'b0; pre = 16'd2; post = 16'd3;
        do_reset();
        tick(1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d = (i < 2) ? 8'h00 : 8'h01;
            tick(1'b1, d, 1'b0, 1'b0);
            n_tests++;
            if (act !== exp_vec) begin n_fail++; $display("FAIL basic_cycle%0d act=%h exp=%h", i, act, exp_vec); end
            caps  += int'(o_capture);
            trigs += int'(o_trig);
            if (i == 2) begin
                n_tests++;
                if ({o_trig, o_capture, o_data} !== 10'b11_0000_0001) begin
                    n_fail++; $display("FAIL basic_trig_sample act=%b%b/%h exp=11/01", o_trig, o_capture, o_data);
                end
            end
        end
        n_tests++;
        if (caps != 6 || trigs != 1) begin n_fail++; $display("FAIL basic_counts caps=%0d trigs=%0d exp=6/1", caps, trigs); end
        n_tests++;
        if (o_state !== 3'd4 || o_done !== 1'b1) begin n_fail++; $display("FAIL basic_done state=%0d done=%b exp=4/1", o_state, o_done); end
    endtask

    task automatic test_and();
        logic [7:0] seq [4];
        seq = '{8'h01, 8'h03, 8'h02, 8'h01};
        mode = 16'h0009; combine = 1'b1; pre = 16'd0; post = 16'd0;
        do_reset();
        tick(1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, seq[i], 1'b0, 1'b0);
            n_tests++;
            if (act !== exp_vec) begin n_fail++; $display("FAIL and_cycle%0d act=%h exp=%h", i, act, exp_vec); end
            n_tests++;
            if (o_trig !== (i == 3)) begin n_fail++; $display("FAIL and_trig%0d act=%b exp=%b", i, o_trig, (i == 3)); end
        end
    endtask

    task automatic test_all_off();
        logic [7:0] d;
        for (int c = 0; c < 2; c++) begin
            mode = 16'h0000; combine = c[0]; pre = 16'd1; post = 16'd1;
            do_reset();
            d = 8'h5A;
            tick(1'b1, d, 1'b1, 1'b0);
            for (int i = 0; i < 12; i++) begin
                d = d ^ 8'($urandom_range(1, 255));
                tick(1'b1, d, 1'b0, 1'b0);
                n_tests++;
                if (act !== exp_vec) begin n_fail++; $display("FAIL off_cycle%0d act=%h exp=%h", i, act, exp_vec); end
                n_tests++;
                if (o_changed !== 1'b1 || o_trig !== 1'b0) begin
                    n_fail++; $display("FAIL off_chg_trig%0d act=%b%b exp=10", i, o_changed, o_trig);
                end
            end
        end
    endtask

    task automatic test_abort_arm_ignore();
        mode = 16'h0001; combine = 1'b0; pre = 16'd0; post = 16'd2;
        do_reset();
        tick(1'b1, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'h01, 1'b0, 1'b1);
        n_tests++;
        if (o_state !== 3'd0 || o_trig !== 1'b0) begin n_fail++; $display("FAIL abort_match state=%0d trig=%b exp=0/0", o_state, o_trig); end
        tick(1'b1, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        n_tests++;
        if (o_state !== 3'd3 || o_trig !== 1'b1) begin n_fail++; $display("FAIL abort_retrig state=%0d trig=%b exp=3/1", o_state, o_trig); end
        tick(1'b1, 8'h01, 1'b1, 1'b0);
        n_tests++;
        if (o_state !== 3'd3) begin n_fail++; $display("FAIL arm_in_post state=%0d exp=3", o_state); end
        tick(1'b1, 8'h01, 1'b1, 1'b0);
        n_tests++;
        if (act !== exp_vec || o_state !== 3'd4) begin n_fail++; $display("FAIL post_end act=%h exp=%h", act, exp_vec); end
    endtask

    task automatic test_zero_window_reset();
        mode = 16'h0001; combine = 1'b0; pre = 16'd0; post = 16'd0;
        do_reset();
        tick(1'b1, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if (o_state !== 3'd2 || o_capture !== 1'b0) begin n_fail++; $display("FAIL zero_armed state=%0d cap=%b exp=2/0", o_state, o_capture); end
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        n_tests++;
        if ({o_state, o_trig, o_capture, o_done} !== 6'b100_1_1_1) begin
            n_fail++; $display("FAIL zero_trig act=%b exp=100111", {o_state, o_trig, o_capture, o_done});
        end
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        n_tests++;
        if (o_capture !== 1'b0) begin n_fail++; $display("FAIL zero_done_cap act=%b exp=0", o_capture); end
        post = 16'd5;
        tick(1'b1, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        n_tests++;
        if (o_state !== 3'd3) begin n_fail++; $display("FAIL reset_pre_post state=%0d exp=3", o_state); end
        rst_n = 1'b0;
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if (act !== 15'd0) begin n_fail++; $display("FAIL reset_in_post act=%h exp=0", act); end
        rst_n = 1'b1;
    endtask

`ifdef PIN_TRIGGER_OCCURRENCE_EN
    task automatic test_occurrence();
        int rises;
        mode = 16'h0001; combine = 1'b0; pre = 16'd0; post = 16'd1; occur = 16'd2;
        do_reset();
        tick(1'b1, 8'h00, 1'b1, 1'b0);
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, i[0] ? 8'h00 : 8'h01, 1'b0, 1'b0);
            if (!i[0]) rises++;
            n_tests++;
            if (o_trig !== (rises == 3 && !i[0])) begin n_fail++; $display("FAIL occur_trig%0d act=%b", i, o_trig); end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ((m_state == 0 || m_state == 4) && $urandom_range(0, 7) == 0) begin
                mode    = 16'($urandom & $urandom);
                combine = 1'($urandom_range(0, 1));
                pre     = 16'($urandom_range(0, 3));
                post    = 16'($urandom_range(0, 3));
                occur   = 16'($urandom_range(0, 2));
            end
            rst_n = ($urandom_range(0, 299) != 0);
            tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 49) == 0);
            n_tests++;
            if (act !== exp_vec) begin n_fail++; $display("FAIL random_cycle%0d act=%h exp=%h", i, act, exp_vec); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; data = 8'h00; mode = 16'h0000; combine = 1'b0;
        pre = 16'd0; post = 16'd0; occur = 16'd0; arm = 1'b0; abort = 1'b0;
        test_reset();
        test_basic();
        test_and();
        test_all_off();
        test_abort_arm_ignore();
        test_zero_window_reset();
`ifdef PIN_TRIGGER_OCCURRENCE_EN
        test_occurrence();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
